// File: rtl/falafel_lsu_arbiter.sv
// rtl/falafel_lsu_arbiter.sv - round-robin LSU arbiter with allocator lock ownership and contention counter
package falafel_lsu_pkg;
    localparam logic [2:0] OP_LOAD           = 3'd0;
    localparam logic [2:0] OP_STORE          = 3'd1;
    localparam logic [2:0] OP_LOCK           = 3'd2;
    localparam logic [2:0] OP_UNLOCK         = 3'd3;
    localparam logic [2:0] OP_EDIT_NEXT_ADDR = 3'd4;

    typedef struct packed {
        logic        val;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
    } header_req_t;

    typedef struct packed {
        logic        val;
        logic [31:0] data;
    } header_rsp_t;
endpackage

module falafel_lsu_arbiter
    import falafel_lsu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 16,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  header_req_t [NUM_REQ-1:0]       req_header_i,
    output logic        [NUM_REQ-1:0]       req_ready_o,
    output header_rsp_t [NUM_REQ-1:0]       rsp_header_o,
    input  logic        [NUM_REQ-1:0]       rsp_ready_i,
    output header_req_t                     lsu_req_header_o,
    input  logic                            lsu_ready_i,
    input  header_rsp_t                     lsu_rsp_header_i,
    output logic                            lsu_rsp_ready_o,
    output logic                            lock_held_o,
    output logic        [IDX_W-1:0]         owner_o,
    output logic        [CNT_W-1:0]         contention_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RSP} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    header_req_t       req_q, req_d;
    logic              lock_held_q, lock_held_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_REQ-1:0] eligible;
    logic               contended;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic               rsp_done;
    logic [IDX_W-1:0]   next_ptr;

    // While locked only the owner may be served; any other pending request counts as contention.
    always_comb begin
        eligible  = '0;
        contended = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_header_i[i].val) begin
                if (!lock_held_q || owner_q == IDX_W'(i)) eligible[i] = 1'b1;
                if (lock_held_q && owner_q != IDX_W'(i)) contended = 1'b1;
            end
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (eligible[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    assign rsp_done = (state_q == S_WAIT_RSP) && lsu_rsp_header_i.val && rsp_ready_i[grant_q];
    assign next_ptr = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (grant_valid) state_d = S_ISSUE;
            S_ISSUE:    if (lsu_ready_i) state_d = S_WAIT_RSP;
            S_WAIT_RSP: if (rsp_done)    state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Accept pulse is gated by reset so nothing is acknowledged while the block is held in reset.
    always_comb begin
        req_ready_o      = '0;
        lsu_req_header_o = '0;
        rsp_header_o     = '0;
        lsu_rsp_ready_o  = 1'b0;
        unique case (state_q)
            S_IDLE: if (grant_valid && rst_ni) req_ready_o[grant_idx] = 1'b1;
            S_ISSUE: begin
                lsu_req_header_o     = req_q;
                lsu_req_header_o.val = 1'b1;
            end
            S_WAIT_RSP: begin
                rsp_header_o[grant_q] = lsu_rsp_header_i;
                lsu_rsp_ready_o       = rsp_ready_i[grant_q];
            end
            default: ;
        endcase
    end

    always_comb begin
        grant_d     = grant_q;
        req_d       = req_q;
        rr_ptr_d    = rr_ptr_q;
        lock_held_d = lock_held_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        if (contended && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (state_q == S_IDLE && grant_valid) begin
            grant_d = grant_idx;
            req_d   = req_header_i[grant_idx];
        end
        if (rsp_done) begin
            if (req_q.op == OP_LOCK) begin
                lock_held_d = 1'b1;
                owner_d     = grant_q;
            end else if (req_q.op == OP_UNLOCK && lock_held_q && owner_q == grant_q) begin
                lock_held_d = 1'b0;
                rr_ptr_d    = next_ptr;
            end else if (!lock_held_q) begin
                rr_ptr_d    = next_ptr;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            owner_q     <= '0;
            req_q       <= '0;
            lock_held_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            req_q       <= req_d;
            lock_held_q <= lock_held_d;
            cnt_q       <= cnt_d;
        end
    end

    assign lock_held_o      = lock_held_q;
    assign owner_o          = owner_q;
    assign contention_cnt_o = cnt_q;

endmodule

// File: tb/tb_falafel_lsu_arbiter.sv
// tb/tb_falafel_lsu_arbiter.sv - directed self-checking bench for falafel_lsu_arbiter
module tb_falafel_lsu_arbiter;
    import falafel_lsu_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int CNT_W   = 16;

    logic                        clk = 1'b0;
    logic                        rst_n;
    header_req_t [NUM_REQ-1:0]   req_hdr;
    logic        [NUM_REQ-1:0]   req_ready;
    header_rsp_t [NUM_REQ-1:0]   rsp_hdr;
    logic        [NUM_REQ-1:0]   rsp_ready;
    header_req_t                 lsu_req;
    logic                        lsu_ready;
    header_rsp_t                 lsu_rsp;
    logic                        lsu_rsp_ready;
    logic                        lock_held;
    logic        [0:0]           owner;
    logic        [CNT_W-1:0]     cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    falafel_lsu_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_header_i     (req_hdr),
        .req_ready_o      (req_ready),
        .rsp_header_o     (rsp_hdr),
        .rsp_ready_i      (rsp_ready),
        .lsu_req_header_o (lsu_req),
        .lsu_ready_i      (lsu_ready),
        .lsu_rsp_header_i (lsu_rsp),
        .lsu_rsp_ready_o  (lsu_rsp_ready),
        .lock_held_o      (lock_held),
        .owner_o          (owner),
        .contention_cnt_o (cnt)
    );

    function automatic header_req_t mk_req(logic v, logic [2:0] op, logic [31:0] addr, logic [31:0] data);
        header_req_t h;
        h.val  = v;
        h.op   = op;
        h.addr = addr;
        h.data = data;
        return h;
    endfunction

    function automatic header_rsp_t mk_rsp(logic v, logic [31:0] data);
        header_rsp_t h;
        h.val  = v;
        h.data = data;
        return h;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge where requester i is being accepted; returns at the first IDLE negedge after completion.
    task automatic serve(input int i, input logic [31:0] rdata);
        @(negedge clk);
        req_hdr[i].val = 1'b0;
        lsu_ready      = 1'b1;
        @(negedge clk);
        lsu_rsp   = mk_rsp(1'b1, rdata);
        rsp_ready = '1;
        @(negedge clk);
        lsu_rsp   = '0;
    endtask

    initial begin
        rst_n      = 1'b0;
        lsu_ready  = 1'b0;
        lsu_rsp    = '0;
        rsp_ready  = '0;
        req_hdr[0] = mk_req(1'b1, OP_LOAD, 32'h10, 32'h0);
        req_hdr[1] = mk_req(1'b1, OP_LOAD, 32'h20, 32'h0);

        @(negedge clk); #1;
        check("rst_req_ready", 128'(req_ready), 128'(2'b00));
        check("rst_lsu_req", 128'(lsu_req), 128'(0));
        check("rst_rsp_hdr", 128'(rsp_hdr), 128'(0));
        check("rst_lsu_rsp_ready", 128'(lsu_rsp_ready), 128'(0));
        check("rst_lock_held", 128'(lock_held), 128'(0));
        check("rst_owner", 128'(owner), 128'(0));
        check("rst_cnt", 128'(cnt), 128'(0));

        @(negedge clk); rst_n = 1'b1; #1;
        check("both_load_grant0", 128'(req_ready), 128'(2'b01));
        @(negedge clk); req_hdr[0].val = 1'b0; lsu_ready = 1'b1; #1;
        check("issue_req0_hdr", 128'(lsu_req), 128'(mk_req(1'b1, OP_LOAD, 32'h10, 32'h0)));
        check("issue_no_ack", 128'(req_ready), 128'(2'b00));
        @(negedge clk); lsu_rsp = mk_rsp(1'b1, 32'hAAAA); rsp_ready = 2'b11; #1;
        check("wait_rsp0_routed", 128'(rsp_hdr[0]), 128'(mk_rsp(1'b1, 32'hAAAA)));
        check("wait_rsp1_zero", 128'(rsp_hdr[1]), 128'(0));
        check("wait_lsu_rsp_ready", 128'(lsu_rsp_ready), 128'(1));
        check("wait_lsu_req_zero", 128'(lsu_req), 128'(0));
        @(negedge clk); lsu_rsp = '0; #1;
        check("req1_after_req0", 128'(req_ready), 128'(2'b10));
        serve(1, 32'hBBBB);

        req_hdr[1] = mk_req(1'b1, OP_LOCK, 32'h100, 32'h0); #1;
        check("lock_grant1", 128'(req_ready), 128'(2'b10));
        serve(1, 32'h1);
        #1;
        check("lock_held_set", 128'(lock_held), 128'(1));
        check("lock_owner1", 128'(owner), 128'(1));
        check("lock_cnt0", 128'(cnt), 128'(0));

        req_hdr[0] = mk_req(1'b1, OP_LOAD, 32'h30, 32'h0);
        req_hdr[1] = mk_req(1'b1, OP_EDIT_NEXT_ADDR, 32'h104, 32'h55); #1;
        check("owner_only_grant", 128'(req_ready), 128'(2'b10));
        @(negedge clk); req_hdr[1].val = 1'b0; lsu_ready = 1'b1; #1;
        check("cnt_1", 128'(cnt), 128'(1));
        check("edit_issue_hdr", 128'(lsu_req), 128'(mk_req(1'b1, OP_EDIT_NEXT_ADDR, 32'h104, 32'h55)));
        @(negedge clk); lsu_rsp = mk_rsp(1'b1, 32'h2); rsp_ready = 2'b11; #1;
        check("cnt_2", 128'(cnt), 128'(2));
        @(negedge clk); lsu_rsp = '0; #1;
        check("cnt_3", 128'(cnt), 128'(3));
        check("req0_blocked", 128'(req_ready), 128'(2'b00));
        check("still_locked", 128'(lock_held), 128'(1));
        @(negedge clk); req_hdr[1] = mk_req(1'b1, OP_UNLOCK, 32'h100, 32'h0); #1;
        check("cnt_4", 128'(cnt), 128'(4));
        check("unlock_grant1", 128'(req_ready), 128'(2'b10));
        @(negedge clk); req_hdr[1].val = 1'b0; lsu_ready = 1'b1; #1;
        check("cnt_5", 128'(cnt), 128'(5));
        @(negedge clk); lsu_rsp = mk_rsp(1'b1, 32'h3); rsp_ready = 2'b10; #1;
        check("unlock_rsp_ready", 128'(lsu_rsp_ready), 128'(1));
        check("lock_before_edge", 128'(lock_held), 128'(1));
        check("cnt_6", 128'(cnt), 128'(6));
        @(negedge clk); lsu_rsp = '0; rsp_ready = 2'b11; lsu_ready = 1'b0; #1;
        check("unlock_released", 128'(lock_held), 128'(0));
        check("cnt_7", 128'(cnt), 128'(7));
        check("req0_after_unlock", 128'(req_ready), 128'(2'b01));

        for (int s = 0; s < 5; s++) begin
            @(negedge clk); req_hdr[0].val = 1'b0; #1;
            check("stall_hdr_stable", 128'(lsu_req), 128'(mk_req(1'b1, OP_LOAD, 32'h30, 32'h0)));
        end
        lsu_ready = 1'b1;
        @(negedge clk); lsu_rsp = mk_rsp(1'b1, 32'hBEEF); rsp_ready = 2'b10; #1;
        check("rsp_stall_ready0", 128'(lsu_rsp_ready), 128'(0));
        check("rsp_stall_route", 128'(rsp_hdr[0]), 128'(mk_rsp(1'b1, 32'hBEEF)));
        @(negedge clk); #1;
        check("rsp_stall_hold", 128'(rsp_hdr[0]), 128'(mk_rsp(1'b1, 32'hBEEF)));
        check("rsp_stall_no_issue", 128'(lsu_req), 128'(0));
        rsp_ready = 2'b11;
        @(negedge clk); lsu_rsp = '0; #1;
        check("cnt_no_lock_hold", 128'(cnt), 128'(7));

        req_hdr[0] = mk_req(1'b1, OP_LOCK, 32'h200, 32'h0); #1;
        check("lock0_grant", 128'(req_ready), 128'(2'b01));
        serve(0, 32'h4);
        req_hdr[1] = mk_req(1'b1, OP_LOAD, 32'h40, 32'h0); #1;
        check("owner0", 128'(owner), 128'(0));
        check("req1_blocked", 128'(req_ready), 128'(2'b00));
        repeat (65527) @(negedge clk);
        #1;
        check("cnt_fffe", 128'(cnt), 128'(16'hFFFE));
        @(negedge clk); #1;
        check("cnt_ffff", 128'(cnt), 128'(16'hFFFF));
        repeat (3) @(negedge clk);
        #1;
        check("cnt_saturated", 128'(cnt), 128'(16'hFFFF));

        req_hdr[1].val = 1'b0;
        req_hdr[0] = mk_req(1'b1, OP_LOAD, 32'h50, 32'h0); #1;
        check("owner_load_grant", 128'(req_ready), 128'(2'b01));
        @(negedge clk); req_hdr[0].val = 1'b0; lsu_ready = 1'b1;
        @(negedge clk); lsu_rsp = mk_rsp(1'b1, 32'h77); rsp_ready = 2'b11; #1;
        check("pre_rst_rsp_ready", 128'(lsu_rsp_ready), 128'(1));
        rst_n = 1'b0;
        req_hdr[0] = mk_req(1'b1, OP_LOAD, 32'h60, 32'h0);
        req_hdr[1] = mk_req(1'b1, OP_LOAD, 32'h70, 32'h0); #1;
        check("midrst_lock", 128'(lock_held), 128'(0));
        check("midrst_cnt", 128'(cnt), 128'(0));
        check("midrst_rsp_ready", 128'(lsu_rsp_ready), 128'(0));
        check("midrst_rsp_hdr", 128'(rsp_hdr), 128'(0));
        check("midrst_req_ready", 128'(req_ready), 128'(2'b00));
        check("midrst_lsu_req", 128'(lsu_req), 128'(0));
        lsu_rsp = '0;
        @(negedge clk); rst_n = 1'b1; #1;
        check("post_rst_grant0", 128'(req_ready), 128'(2'b01));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
